// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder
// Description : Multi-cycle add/subtract unit. Processes two WIDTH-bit
//               operands CHUNK bits per clock, rippling the carry between
//               chunks through a register. Start/busy/done handshake.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               start    - request, sampled only while busy is low
//               sub      - 0: a+b+cin, 1: a-b (cin ignored)
//               a, b     - operands, sampled with an accepted start
//               cin      - carry-in for add mode, sampled with start
//               busy     - operation in progress
//               done     - one-cycle pulse, result valid
//               sum      - result, held until the next result is produced
//               cout     - carry out of the MSB (sub: 1 = no borrow)
//               overflow - signed two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int c_n     = WIDTH / CHUNK;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    generate
        if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;      // already inverted for subtraction
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;

    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK:0]     w_chunk_sum;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_ovf;

    // Current chunk slice plus the result as it will look after this edge,
    // so the final edge can register sum/overflow without an extra cycle.
    always_comb begin
        w_chunk_a   = r_op_a[r_cnt*CHUNK +: CHUNK];
        w_chunk_b   = r_op_b[r_cnt*CHUNK +: CHUNK];
        w_chunk_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, r_carry};
        w_res_next  = r_res;
        w_res_next[r_cnt*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
        w_ovf       = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                      (w_res_next[WIDTH-1] != r_op_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert now, seed carry with 1.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_res   <= w_res_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    if (r_cnt == c_last_cnt) begin
                        sum      <= w_res_next;
                        cout     <= w_chunk_sum[CHUNK];
                        overflow <= w_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
